pipe_readout_fsm: RTL and testbench

- Consumer at the output end of the SCA/ADC sample pipeline.
- The pipeline start controller fills the circular pipeline and then holds it in run mode (read and write enabled).
- This block waits for run mode, accepts L1A triggers and copies NSAMP consecutive pipeline output words per trigger into the downstream sample FIFO.
- Triggers arriving while a capture is in progress are queued, and each event is terminated with a LAST flag.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_readout_fsm_tmr_vote.sv | 16 +
 rtl/pipe_readout_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_readout_fsm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline readout slice.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_READY   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_GAP     = 2'b11
    } state_t;

    localparam int unsigned DW_DEF  = 12;
    localparam int unsigned NSW_DEF = 5;
    localparam int unsigned EVW_DEF = 12;
    // Pending-trigger counter width; covers PEND_MAX up to 7.
    localparam int unsigned PEND_W  = 3;

endpackage

// File: rtl/pipe_readout_fsm_tmr_vote.sv
// N-bit bitwise 2-of-3 majority voter.
module tmr_vote #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_c,
    output logic [N-1:0] o_y
);

    // Bitwise majority of the three copies.
    always_comb begin
        o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    end

endmodule

// File: rtl/pipe_readout_fsm.sv
// Pipeline readout FSM: waits for pipeline run mode, queues L1A triggers and
// copies NSAMP consecutive pipeline words per trigger into the sample FIFO.
// Optional macro PIPE_READOUT_TMR_EN triplicates all state/output registers
// and feeds every copy from the majority-voted value.
module pipe_readout_fsm
    import pipe_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned NSW      = NSW_DEF,
    parameter int unsigned PEND_MAX = 4,
    parameter int unsigned EVW      = EVW_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           PIPE_RUN,
    input  logic [DW-1:0]  PIPE_DOUT,
    input  logic           L1A,
    input  logic [NSW-1:0] NSAMP,
    input  logic           FIFO_AFULL,
    output logic           SMP_WE,
    output logic [DW-1:0]  SMP_DATA,
    output logic           SMP_LAST,
    output logic           BUSY,
    output logic           DROP,
    output logic           ABORT,
    output logic [EVW-1:0] EVT_CNT
);

`ifdef PIPE_READOUT_TMR_EN
    localparam int unsigned NCOPY = 3;
    (* syn_preserve = 1 *) state_t            r_state [NCOPY];
    (* syn_preserve = 1 *) logic [NSW-1:0]    r_cnt   [NCOPY];
    (* syn_preserve = 1 *) logic [PEND_W-1:0] r_pend  [NCOPY];
    (* syn_preserve = 1 *) logic [EVW-1:0]    r_evt   [NCOPY];
    (* syn_preserve = 1 *) logic              r_we    [NCOPY];
    (* syn_preserve = 1 *) logic [DW-1:0]     r_data  [NCOPY];
    (* syn_preserve = 1 *) logic              r_last  [NCOPY];
    (* syn_preserve = 1 *) logic              r_busy  [NCOPY];
    (* syn_preserve = 1 *) logic              r_drop  [NCOPY];
    (* syn_preserve = 1 *) logic              r_abort [NCOPY];
`else
    localparam int unsigned NCOPY = 1;
    state_t            r_state [NCOPY];
    logic [NSW-1:0]    r_cnt   [NCOPY];
    logic [PEND_W-1:0] r_pend  [NCOPY];
    logic [EVW-1:0]    r_evt   [NCOPY];
    logic              r_we    [NCOPY];
    logic [DW-1:0]     r_data  [NCOPY];
    logic              r_last  [NCOPY];
    logic              r_busy  [NCOPY];
    logic              r_drop  [NCOPY];
    logic              r_abort [NCOPY];
`endif

    // Current (voted when triplicated) register values.
    state_t            w_state;
    logic [NSW-1:0]    w_cnt;
    logic [PEND_W-1:0] w_pend;
    logic [EVW-1:0]    w_evt;
    logic              w_we;
    logic [DW-1:0]     w_data;
    logic              w_last;
    logic              w_busy;
    logic              w_drop;
    logic              w_abort;

`ifdef PIPE_READOUT_TMR_EN
    localparam int unsigned SW = 2 + NSW + PEND_W + EVW + DW + 5;
    logic [SW-1:0] w_cp [3];
    (* syn_keep = 1 *) logic [SW-1:0] w_vote;
    logic [1:0]    w_state_bits;

    // Pack each copy into one vector so a single voter covers all fields.
    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            w_cp[c] = {r_state[c], r_cnt[c], r_pend[c], r_evt[c], r_we[c],
                       r_data[c], r_last[c], r_busy[c], r_drop[c], r_abort[c]};
        end
    end

    tmr_vote #(.N(SW)) u_vote (
        .i_a (w_cp[0]),
        .i_b (w_cp[1]),
        .i_c (w_cp[2]),
        .o_y (w_vote)
    );

    assign {w_state_bits, w_cnt, w_pend, w_evt, w_we,
            w_data, w_last, w_busy, w_drop, w_abort} = w_vote;
    assign w_state = state_t'(w_state_bits);
`else
    assign w_state = r_state[0];
    assign w_cnt   = r_cnt[0];
    assign w_pend  = r_pend[0];
    assign w_evt   = r_evt[0];
    assign w_we    = r_we[0];
    assign w_data  = r_data[0];
    assign w_last  = r_last[0];
    assign w_busy  = r_busy[0];
    assign w_drop  = r_drop[0];
    assign w_abort = r_abort[0];
`endif

    assign SMP_WE   = w_we;
    assign SMP_DATA = w_data;
    assign SMP_LAST = w_last;
    assign BUSY     = w_busy;
    assign DROP     = w_drop;
    assign ABORT    = w_abort;
    assign EVT_CNT  = w_evt;

    logic [NSW-1:0]    w_nsamp_ld;
    logic              w_pend_nz;
    logic              w_pend_full;
    logic              w_start;
    logic              w_l1a_drop;
    logic [PEND_W-1:0] w_pend_inc;

    assign w_nsamp_ld  = (NSAMP == '0) ? NSW'(1) : NSAMP;
    assign w_pend_nz   = (w_pend != '0);
    assign w_pend_full = (w_pend == PEND_W'(PEND_MAX));
    assign w_start     = PIPE_RUN && (L1A || w_pend_nz) && !FIFO_AFULL;
    assign w_l1a_drop  = L1A && w_pend_full;
    assign w_pend_inc  = (L1A && !w_pend_full) ? w_pend + PEND_W'(1) : w_pend;

    // FSM, pending queue, event counter and registered outputs; every copy
    // loads the same next value derived from the voted current state. BUSY is
    // computed from the next state/pend so it stays aligned with them.
    always_ff @(posedge CLK) begin
        for (int unsigned c = 0; c < NCOPY; c++) begin
            if (RST) begin
                r_state[c] <= ST_IDLE;
                r_cnt[c]   <= '0;
                r_pend[c]  <= '0;
                r_evt[c]   <= '0;
                r_we[c]    <= 1'b0;
                r_data[c]  <= '0;
                r_last[c]  <= 1'b0;
                r_busy[c]  <= 1'b0;
                r_drop[c]  <= 1'b0;
                r_abort[c] <= 1'b0;
            end else begin
                r_state[c] <= w_state;
                r_cnt[c]   <= w_cnt;
                r_pend[c]  <= w_pend;
                r_evt[c]   <= w_evt;
                r_we[c]    <= 1'b0;
                r_data[c]  <= w_data;
                r_last[c]  <= 1'b0;
                r_busy[c]  <= w_pend_nz;
                r_drop[c]  <= 1'b0;
                r_abort[c] <= 1'b0;
                case (w_state)
                    ST_IDLE: begin
                        if (PIPE_RUN) r_state[c] <= ST_READY;
                    end
                    ST_READY: begin
                        if (w_start) begin
                            r_state[c] <= ST_CAPTURE;
                            r_cnt[c]   <= w_nsamp_ld;
                            r_busy[c]  <= 1'b1;
                            // Consume from pend unless a new L1A replaces it.
                            if (w_pend_nz && !L1A) r_pend[c] <= w_pend - PEND_W'(1);
                        end else begin
                            if (!PIPE_RUN) r_state[c] <= ST_IDLE;
                            r_pend[c] <= w_pend_inc;
                            r_drop[c] <= w_l1a_drop;
                            r_busy[c] <= w_pend_nz || L1A;
                        end
                    end
                    ST_CAPTURE: begin
                        if (!PIPE_RUN) begin
                            r_state[c] <= ST_IDLE;
                            r_abort[c] <= 1'b1;
                            r_pend[c]  <= '0;
                            r_cnt[c]   <= '0;
                            r_busy[c]  <= 1'b0;
                        end else begin
                            r_we[c]   <= 1'b1;
                            r_data[c] <= PIPE_DOUT;
                            r_cnt[c]  <= w_cnt - NSW'(1);
                            r_pend[c] <= w_pend_inc;
                            r_drop[c] <= w_l1a_drop;
                            r_busy[c] <= 1'b1;
                            if (w_cnt <= NSW'(1)) begin
                                r_last[c]  <= 1'b1;
                                r_state[c] <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        r_state[c] <= ST_READY;
                        r_evt[c]   <= w_evt + EVW'(1);
                        r_pend[c]  <= w_pend_inc;
                        r_drop[c]  <= w_l1a_drop;
                        r_busy[c]  <= w_pend_nz || L1A;
                    end
                    default: r_state[c] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_readout_fsm.sv
// Self-checking bench for pipe_readout_fsm: scoreboard of expected sample
// words filled as triggers are driven, drained as SMP_WE words appear.
module tb_pipe_readout_fsm;
    import pipe_pkg::*;

    localparam int unsigned DW  = 12;
    localparam int unsigned NSW = 5;
    localparam int unsigned EVW = 12;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           PIPE_RUN = 1'b0;
    logic [DW-1:0]  PIPE_DOUT = '0;
    logic           L1A = 1'b0;
    logic [NSW-1:0] NSAMP = 5'd8;
    logic           FIFO_AFULL = 1'b0;
    logic           SMP_WE;
    logic [DW-1:0]  SMP_DATA;
    logic           SMP_LAST;
    logic           BUSY;
    logic           DROP;
    logic           ABORT;
    logic [EVW-1:0] EVT_CNT;

    pipe_readout_fsm #(.DW(DW), .NSW(NSW), .PEND_MAX(4), .EVW(EVW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PIPE_RUN   (PIPE_RUN),
        .PIPE_DOUT  (PIPE_DOUT),
        .L1A        (L1A),
        .NSAMP      (NSAMP),
        .FIFO_AFULL (FIFO_AFULL),
        .SMP_WE     (SMP_WE),
        .SMP_DATA   (SMP_DATA),
        .SMP_LAST   (SMP_LAST),
        .BUSY       (BUSY),
        .DROP       (DROP),
        .ABORT      (ABORT),
        .EVT_CNT    (EVT_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t        q[$];
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned cyc     = 0;
    int unsigned drop_seen  = 0;
    int unsigned abort_seen = 0;
    int unsigned exp_evt    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue n words of a ramp starting at v; last flag on the final word if tagged.
    task automatic push_evt(input int unsigned v, input int unsigned n, input bit with_last);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.d = DW'(v + i);
            e.l = with_last && (i == n - 1);
            q.push_back(e);
        end
    endtask

    // One clock: sample outputs #1 after the edge, advance the ramp, score writes.
    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        PIPE_DOUT = DW'(cyc);
        if (DROP)  drop_seen++;
        if (ABORT) abort_seen++;
        if (SMP_WE) begin
            if (q.size() == 0) begin
                check("spurious_we", 32'(SMP_DATA), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("smp_data", 32'(SMP_DATA), 32'(e.d));
                check("smp_last", 32'(SMP_LAST), 32'(e.l));
            end
        end else if (SMP_LAST) begin
            check("last_without_we", 32'(SMP_LAST), 32'd0);
        end
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while (q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned nloop;

        // Reset state
        step(); step();
        check("rst_we",    32'(SMP_WE),   32'd0);
        check("rst_data",  32'(SMP_DATA), 32'd0);
        check("rst_last",  32'(SMP_LAST), 32'd0);
        check("rst_busy",  32'(BUSY),     32'd0);
        check("rst_drop",  32'(DROP),     32'd0);
        check("rst_abort", 32'(ABORT),    32'd0);
        check("rst_evt",   32'(EVT_CNT),  32'd0);
        RST = 1'b0;

        // L1A in Idle is ignored
        L1A = 1'b1; step(); L1A = 1'b0;
        check("idle_l1a_busy", 32'(BUSY), 32'd0);
        check("idle_l1a_drop", 32'(DROP), 32'd0);

        // Basic capture, NSAMP=8
        PIPE_RUN = 1'b1; step(); step();
        NSAMP = 5'd8;
        push_evt(cyc + 1, 8, 1'b1);
        L1A = 1'b1; step(); L1A = 1'b0;
        drain("basic_drain");
        step(); step();
        exp_evt++;
        check("basic_evt",  32'(EVT_CNT), 32'(exp_evt));
        check("basic_drop", 32'(drop_seen), 32'd0);
        check("basic_busy", 32'(BUSY), 32'd0);

        // Queued triggers every 3 cycles; 7th finds pend=4 and is dropped.
        // Events then run every 10 edges (8 words, Gap, Ready).
        c0 = cyc;
        for (int unsigned t = 0; t <= 18; t++) begin
            L1A = (t % 3 == 0);
            if (L1A && t / 3 < 6) push_evt(c0 + 1 + 10 * (t / 3), 8, 1'b1);
            step();
            if (t == 18) check("queue_drop_pulse", 32'(DROP), 32'd1);
            if (t == 17) check("queue_busy", 32'(BUSY), 32'd1);
        end
        L1A = 1'b0;
        drain("queue_drain");
        step(); step();
        exp_evt += 6;
        check("queue_evt",       32'(EVT_CNT),   32'(exp_evt));
        check("queue_drop_once", 32'(drop_seen), 32'd1);
        check("queue_busy_end",  32'(BUSY),      32'd0);

        // Back-pressure: trigger held as pending while FIFO_AFULL=1
        NSAMP = 5'd3;
        FIFO_AFULL = 1'b1;
        L1A = 1'b1; step(); L1A = 1'b0;
        step(); step(); step();
        check("bp_busy",  32'(BUSY),      32'd1);
        check("bp_queue", 32'(q.size()),  32'd0);
        push_evt(cyc + 1, 3, 1'b1);
        FIFO_AFULL = 1'b0;
        step();
        check("bp_no_we_yet", 32'(SMP_WE), 32'd0);
        step();
        check("bp_first_we", 32'(SMP_WE), 32'd1);
        drain("bp_drain");
        step(); step();
        exp_evt++;
        check("bp_evt", 32'(EVT_CNT), 32'(exp_evt));

        // NSAMP=0 behaves as one sample
        NSAMP = 5'd0;
        push_evt(cyc + 1, 1, 1'b1);
        L1A = 1'b1; step(); L1A = 1'b0;
        drain("ns0_drain");
        step(); step();
        exp_evt++;
        check("ns0_evt", 32'(EVT_CNT), 32'(exp_evt));

        // Abort after third word of an 8-word event
        NSAMP = 5'd8;
        push_evt(cyc + 1, 3, 1'b0);
        L1A = 1'b1; step(); L1A = 1'b0;
        step(); step(); step();
        PIPE_RUN = 1'b0;
        step();
        check("abort_pulse", 32'(ABORT), 32'd1);
        check("abort_we",    32'(SMP_WE), 32'd0);
        check("abort_words", 32'(q.size()), 32'd0);
        step();
        check("abort_once", 32'(abort_seen), 32'd1);
        check("abort_evt",  32'(EVT_CNT), 32'(exp_evt));
        check("abort_busy", 32'(BUSY), 32'd0);
        L1A = 1'b1; step(); L1A = 1'b0;
        check("abort_idle_busy", 32'(BUSY), 32'd0);

        // Event counter wrap with single-sample events
        PIPE_RUN = 1'b1; step(); step();
        NSAMP = 5'd1;
        nloop = 4095 - exp_evt;
        for (int unsigned i = 0; i < nloop; i++) begin
            push_evt(cyc + 1, 1, 1'b1);
            L1A = 1'b1; step(); L1A = 1'b0;
            step(); step();
        end
        check("wrap_4095", 32'(EVT_CNT), 32'd4095);
        push_evt(cyc + 1, 1, 1'b1);
        L1A = 1'b1; step(); L1A = 1'b0;
        step(); step();
        check("wrap_zero", 32'(EVT_CNT), 32'd0);
        drain("wrap_drain");
        exp_evt = 0;

`ifdef PIPE_READOUT_TMR_EN
        // Upset one state copy mid-capture; voted outputs stay correct
        NSAMP = 5'd8;
        push_evt(cyc + 1, 8, 1'b1);
        L1A = 1'b1; step(); L1A = 1'b0;
        step(); step(); step();
        dut.r_state[1] = ST_IDLE;
        step();
        check("tmr_restore", 32'(dut.r_state[1]), 32'(ST_CAPTURE));
        drain("tmr_drain");
        step(); step();
        exp_evt++;
        check("tmr_evt", 32'(EVT_CNT), 32'(exp_evt));
`endif

        // Reset in the middle of a capture
        NSAMP = 5'd8;
        push_evt(cyc + 1, 8, 1'b1);
        L1A = 1'b1; step(); L1A = 1'b0;
        step(); step(); step();
        check("mid_we_active", 32'(SMP_WE), 32'd1);
        RST = 1'b1;
        step();
        q.delete();
        check("mid_rst_we",   32'(SMP_WE),   32'd0);
        check("mid_rst_data", 32'(SMP_DATA), 32'd0);
        check("mid_rst_last", 32'(SMP_LAST), 32'd0);
        check("mid_rst_busy", 32'(BUSY),     32'd0);
        check("mid_rst_evt",  32'(EVT_CNT),  32'd0);
        RST = 1'b0;
        step(); step();
        check("post_rst_we", 32'(SMP_WE), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
